// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: drives the PC register and a req/ack instruction-memory port.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets divert to EXC_VECTOR and raise adel_o.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic        eret_valid,
  input  logic [31:0] epc_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        pc_en,
  output logic [31:0] next_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        adel_o,
  output logic [31:0] bad_addr_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic        pend_v;
  logic [31:0] pend_pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] load_raw;
  logic        apply_redir;
  logic        accept_word;

  function automatic logic [31:0] redirect_pc(input logic [31:0] target);
`ifdef FETCH_ALIGN_CHECK_EN
    return (target[1:0] != 2'b00) ? EXC_VECTOR : target;
`else
    return target;
`endif
  endfunction

  // Fixed-priority redirect select; lower-priority events in the same cycle are dropped.
  always_comb begin
    redir    = exc_valid | eret_valid | br_valid;
    redir_pc = exc_valid ? EXC_VECTOR : (eret_valid ? epc_i : br_target);
    load_raw = redir ? redir_pc : pend_pc;
  end

  always_comb begin
    apply_redir = 1'b0;
    accept_word = 1'b0;
    if (!reset) begin
      if (state == S_REQ && imem_ack) begin
        apply_redir = redir | pend_v;
        accept_word = !(redir | pend_v);
      end else if (state == S_HOLD) begin
        apply_redir = redir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (accept_word && stall_i) state_nxt = S_HOLD;
      S_HOLD:  if (redir || !stall_i) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = 32'h0;
    pc_en       = 1'b0;
    next_pc     = (reset || state == S_IDLE) ? RESET_PC : pc_i;
    instr_valid = 1'b0;
    instr       = 32'h0;
    instr_pc    = 32'h0;
    if (!reset) begin
      case (state)
        S_REQ: begin
          imem_req  = 1'b1;
          imem_addr = pc_i;
          if (apply_redir) begin
            pc_en   = 1'b1;
            next_pc = redirect_pc(load_raw);
          end else if (accept_word) begin
            instr_valid = 1'b1;
            instr       = imem_rdata;
            instr_pc    = pc_i;
            if (!stall_i) begin
              pc_en   = 1'b1;
              next_pc = pc_i + 32'd4;
            end
          end
        end
        S_HOLD: begin
          instr_valid = 1'b1;
          instr       = hold_instr;
          instr_pc    = hold_pc;
          if (apply_redir) begin
            pc_en   = 1'b1;
            next_pc = redirect_pc(load_raw);
          end else if (!stall_i) begin
            pc_en   = 1'b1;
            next_pc = hold_pc + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  // A redirect that cannot be loaded this cycle is parked; a newer one overwrites it.
  always_ff @(posedge clk) begin
    if (reset)                 pend_v <= 1'b0;
    else if (redir && !pc_en)  pend_v <= 1'b1;
    else if (apply_redir)      pend_v <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (redir && !pc_en) pend_pc <= redir_pc;
  end

  always_ff @(posedge clk) begin
    if (accept_word && stall_i) begin
      hold_instr <= imem_rdata;
      hold_pc    <= pc_i;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_comb begin
    adel_o     = apply_redir && (load_raw[1:0] != 2'b00);
    bad_addr_o = adel_o ? load_raw : 32'h0;
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand sequences and randomized run vs a reference model.
module tb_fetch_sequencer;
  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam logic [31:0] EXC = 32'h0000_4180;
  localparam logic [31:0] TBL_WORD = 32'h2408_0001;

  logic        clk = 1'b0;
  logic        reset, stall_i, br_valid, exc_valid, eret_valid, imem_ack;
  logic [31:0] pc_i, br_target, epc_i, imem_rdata;
  logic        imem_req, pc_en, instr_valid;
  logic [31:0] imem_addr, next_pc, instr, instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        adel_o;
  logic [31:0] bad_addr_o;
`endif

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .stall_i(stall_i),
    .br_valid(br_valid), .br_target(br_target), .exc_valid(exc_valid),
    .eret_valid(eret_valid), .epc_i(epc_i), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_en(pc_en), .next_pc(next_pc), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    , .adel_o(adel_o), .bad_addr_o(bad_addr_o)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, stall, br, exc, eret, ack;
    logic [31:0] tgt, epc;
    logic req;  logic [31:0] addr;
    logic pen;  logic [31:0] npc;
    logic val;  logic [31:0] ipc;
  } vec_t;

  function automatic vec_t v(input logic rst, stall, br, exc, eret, ack,
                             input logic [31:0] tgt, epc,
                             input logic req, input logic [31:0] addr,
                             input logic pen, input logic [31:0] npc,
                             input logic val, input logic [31:0] ipc);
    vec_t r;
    r.rst = rst; r.stall = stall; r.br = br; r.exc = exc; r.eret = eret; r.ack = ack;
    r.tgt = tgt; r.epc = epc; r.req = req; r.addr = addr; r.pen = pen; r.npc = npc;
    r.val = val; r.ipc = ipc;
    return r;
  endfunction

  // Memory latency model and PC register emulation
  int unsigned age = 0, lat = 0;
  logic        s_rst, s_pen, s_req, s_ack;
  logic [31:0] s_npc;

  task automatic drive(input logic rst, stall, br, exc, eret,
                       input logic [31:0] tgt, epc, input int ack_mode);
    reset = rst; stall_i = stall; br_valid = br; exc_valid = exc; eret_valid = eret;
    br_target = tgt; epc_i = epc;
    if (ack_mode < 0) imem_ack = imem_req && (age >= lat);
    else              imem_ack = (ack_mode != 0);
    imem_rdata = imem_addr ^ 32'h2408_0001;
  endtask

  task automatic end_cycle();
    s_rst = reset; s_pen = pc_en; s_npc = next_pc; s_req = imem_req; s_ack = imem_ack;
    @(posedge clk); #1;
    pc_i = s_rst ? RPC : (s_pen ? s_npc : pc_i);
    if (s_rst) age = 0;
    else if (s_ack) begin age = 0; lat = $urandom_range(0, 3); end
    else if (s_req) age++;
  endtask

  // Reference model: what the fetch stage is doing, from the behavioural rules
  typedef enum {PH_RECOVER, PH_FETCH, PH_HOLD} phase_t;
  phase_t      m_phase = PH_RECOVER;
  logic        m_have_pend = 1'b0;
  logic [31:0] m_pend = 32'h0, m_held_word = 32'h0, m_held_pc = 32'h0;
  logic        e_req, e_pen, e_val;
  logic [31:0] e_addr, e_npc, e_ins, e_ipc;

  function automatic logic [31:0] loadable(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
    if (t % 4 != 0) return EXC;
`endif
    return t;
  endfunction

  task automatic model_eval();
    logic        r;
    logic [31:0] rt;
    r  = exc_valid | eret_valid | br_valid;
    rt = exc_valid ? EXC : (eret_valid ? epc_i : br_target);
    e_req = 0; e_addr = 0; e_pen = 0; e_npc = 0; e_val = 0; e_ins = 0; e_ipc = 0;
    if (reset) begin
      e_npc = RPC; m_phase = PH_RECOVER; m_have_pend = 0;
    end else if (m_phase == PH_RECOVER) begin
      if (r) begin m_have_pend = 1; m_pend = rt; end
      m_phase = PH_FETCH;
    end else if (m_phase == PH_FETCH) begin
      e_req = 1; e_addr = pc_i;
      if (!imem_ack) begin
        if (r) begin m_have_pend = 1; m_pend = rt; end
      end else if (r || m_have_pend) begin
        e_pen = 1; e_npc = loadable(r ? rt : m_pend); m_have_pend = 0;
      end else begin
        e_val = 1; e_ins = imem_rdata; e_ipc = pc_i;
        if (!stall_i) begin e_pen = 1; e_npc = pc_i + 4; end
        else begin m_held_word = imem_rdata; m_held_pc = pc_i; m_phase = PH_HOLD; end
      end
    end else begin
      e_val = 1; e_ins = m_held_word; e_ipc = m_held_pc;
      if (r) begin e_pen = 1; e_npc = loadable(rt); m_phase = PH_FETCH; end
      else if (!stall_i) begin e_pen = 1; e_npc = m_held_pc + 4; m_phase = PH_FETCH; end
    end
  endtask

  task automatic mcycle(input logic rst, stall, br, exc, eret,
                        input logic [31:0] tgt, epc, input int ack_mode);
    logic was_rst;
    drive(rst, stall, br, exc, eret, tgt, epc, ack_mode);
    was_rst = rst;
    model_eval();
    @(negedge clk);
    chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
    chk("pc_en", {31'h0, pc_en}, {31'h0, e_pen});
    chk("instr_valid", {31'h0, instr_valid}, {31'h0, e_val});
    if (e_req) chk("imem_addr", imem_addr, e_addr);
    if (e_pen || was_rst) chk("next_pc", next_pc, e_npc);
    if (e_val) begin
      chk("instr", instr, e_ins);
      chk("instr_pc", instr_pc, e_ipc);
    end
    end_cycle();
  endtask

  vec_t tbl[20];

  initial begin
    tbl[0]  = v(1,0,0,0,0,0, 0,0,                     0,0,        0,RPC,          0,0);
    tbl[1]  = v(0,0,0,0,0,0, 0,0,                     0,0,        0,0,            0,0);
    tbl[2]  = v(0,0,0,0,0,1, 0,0,                     1,32'h3000, 1,32'h3004,     1,32'h3000);
    tbl[3]  = v(0,0,0,0,0,1, 0,0,                     1,32'h3004, 1,32'h3008,     1,32'h3004);
    tbl[4]  = v(0,1,0,0,0,1, 0,0,                     1,32'h3008, 0,0,            1,32'h3008);
    tbl[5]  = v(0,1,0,0,0,0, 0,0,                     0,0,        0,0,            1,32'h3008);
    tbl[6]  = v(0,1,0,0,0,0, 0,0,                     0,0,        0,0,            1,32'h3008);
    tbl[7]  = v(0,0,0,0,0,0, 0,0,                     0,0,        1,32'h300C,     1,32'h3008);
    tbl[8]  = v(0,0,0,0,0,1, 0,0,                     1,32'h300C, 1,32'h3010,     1,32'h300C);
    tbl[9]  = v(0,0,1,0,0,0, 32'h3100,0,              1,32'h3010, 0,0,            0,0);
    tbl[10] = v(0,0,0,0,0,0, 0,0,                     1,32'h3010, 0,0,            0,0);
    tbl[11] = v(0,0,0,0,0,1, 0,0,                     1,32'h3010, 1,32'h3100,     0,0);
    tbl[12] = v(0,0,0,0,0,1, 0,0,                     1,32'h3100, 1,32'h3104,     1,32'h3100);
    tbl[13] = v(0,0,1,1,1,1, 32'h3200,32'h3020,       1,32'h3104, 1,EXC,          0,0);
    tbl[14] = v(0,0,0,0,1,1, 0,32'h3020,              1,EXC,      1,32'h3020,     0,0);
    tbl[15] = v(0,0,0,0,0,1, 0,0,                     1,32'h3020, 1,32'h3024,     1,32'h3020);
    tbl[16] = v(0,0,0,0,0,0, 0,0,                     1,32'h3024, 0,0,            0,0);
    tbl[17] = v(1,0,0,0,0,0, 0,0,                     0,0,        0,RPC,          0,0);
    tbl[18] = v(0,0,0,0,0,1, 0,0,                     0,0,        0,0,            0,0);
    tbl[19] = v(0,0,0,0,0,1, 0,0,                     1,32'h3000, 1,32'h3004,     1,32'h3000);

    pc_i = 32'h0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].exc, tbl[i].eret,
            tbl[i].tgt, tbl[i].epc, tbl[i].ack ? 1 : 0);
      imem_rdata = TBL_WORD;
      @(negedge clk);
      chk($sformatf("tbl%0d imem_req", i), {31'h0, imem_req}, {31'h0, tbl[i].req});
      chk($sformatf("tbl%0d pc_en", i), {31'h0, pc_en}, {31'h0, tbl[i].pen});
      chk($sformatf("tbl%0d instr_valid", i), {31'h0, instr_valid}, {31'h0, tbl[i].val});
      if (tbl[i].req) chk($sformatf("tbl%0d imem_addr", i), imem_addr, tbl[i].addr);
      if (tbl[i].pen || tbl[i].rst) chk($sformatf("tbl%0d next_pc", i), next_pc, tbl[i].npc);
      if (tbl[i].val) begin
        chk($sformatf("tbl%0d instr_pc", i), instr_pc, tbl[i].ipc);
        chk($sformatf("tbl%0d instr", i), instr, TBL_WORD);
      end
      if (tbl[i].rst) begin
        chk($sformatf("tbl%0d reset instr", i), instr, 32'h0);
        chk($sformatf("tbl%0d reset instr_pc", i), instr_pc, 32'h0);
      end
      end_cycle();
    end

    // Newest pending redirect wins; redirect out of a stalled hold.
    mcycle(1, 0, 0, 0, 0, 0, 0, 0);
    mcycle(0, 0, 0, 0, 0, 0, 0, 0);
    mcycle(0, 0, 1, 0, 0, 32'h3100, 0, 0);
    mcycle(0, 0, 0, 0, 1, 0, 32'h3200, 0);
    mcycle(0, 0, 0, 0, 0, 0, 0, 1);
    chk("newest_pending_wins", pc_i, 32'h3200);
    mcycle(0, 1, 0, 0, 0, 0, 0, 1);
    mcycle(0, 1, 1, 0, 0, 32'h3300, 0, 0);
    chk("hold_redirect", pc_i, 32'h3300);
    mcycle(0, 0, 0, 0, 0, 0, 0, 1);
`ifdef FETCH_ALIGN_CHECK_EN
    drive(0, 0, 1, 0, 0, 32'h3102, 0, 1);
    model_eval();
    @(negedge clk);
    chk("adel_o", {31'h0, adel_o}, 32'h1);
    chk("bad_addr_o", bad_addr_o, 32'h3102);
    chk("adel next_pc", next_pc, EXC);
    end_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("adel_o pulse", {31'h0, adel_o}, 32'h0);
    end_cycle();
    mcycle(1, 0, 0, 0, 0, 0, 0, 0);
`endif

    // Randomized run against the reference model
    for (int n = 0; n < 1500; n++) begin
      mcycle(($urandom % 200) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
             ($urandom % 24) == 0, ($urandom % 16) == 0,
             $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
